// File: rtl/backtrack_unit.sv
// Conflict backtracking controller: unwinds forced trail entries down to the most recent
// decision, then pushes that decision back as a forced entry with its value flipped.
//
//   state | meaning
//   IDLE  | waiting for a conflict pulse; depth holds last result
//   POP   | pop request to the trail stack
//   CHECK | popped entry visible on stack_*_out; clear its variable
//   PUSH  | push flipped decision as forced, issue reassignment
//   DONE  | backtrack finished
//   UNSAT | no decision left on the trail
module backtrack_unit #(
    parameter int VARIABLE_INDEXES = 128,
    parameter int NUM_VARIABLE     = 8,
    localparam int DEPTH_W         = $clog2(NUM_VARIABLE + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stack_empty,
    input  logic                        stack_type_out,
    input  logic                        stack_val_out,
    input  logic [VARIABLE_INDEXES-1:0] stack_var_out,
    output logic                        stack_pop,
    output logic                        stack_push,
    output logic                        stack_type_in,
    output logic                        stack_val_in,
    output logic [VARIABLE_INDEXES-1:0] stack_var_in,
    output logic                        unassign_valid,
    output logic [VARIABLE_INDEXES-1:0] unassign_var,
    output logic                        assign_valid,
    output logic [VARIABLE_INDEXES-1:0] assign_var,
    output logic                        assign_val,
    output logic                        done,
    output logic                        unsat,
    output logic                        busy,
    output logic [DEPTH_W-1:0]          backtrack_depth
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CHECK = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4,
        UNSAT = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [DEPTH_W-1:0]          depth_q, depth_d;
    logic [VARIABLE_INDEXES-1:0] var_q, var_d;
    logic                        val_q, val_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            depth_q <= '0;
            var_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            var_q   <= var_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        depth_d        = depth_q;
        var_d          = var_q;
        val_d          = val_q;
        stack_pop      = 1'b0;
        stack_push     = 1'b0;
        stack_type_in  = 1'b0;
        stack_val_in   = 1'b0;
        stack_var_in   = '0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        assign_valid   = 1'b0;
        assign_var     = '0;
        assign_val     = 1'b0;
        done           = 1'b0;
        unsat          = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    depth_d = '0;
                    state_d = stack_empty ? UNSAT : POP;
                end
            end
            POP: begin
                stack_pop = 1'b1;
                state_d   = CHECK;
            end
            CHECK: begin
                unassign_valid = 1'b1;
                unassign_var   = stack_var_out;
                if (depth_q != DEPTH_W'(NUM_VARIABLE)) begin
                    depth_d = depth_q + DEPTH_W'(1);
                end
                if (!stack_type_out) begin
                    var_d   = stack_var_out;
                    val_d   = ~stack_val_out;
                    state_d = PUSH;
                end else if (stack_empty) begin
                    state_d = UNSAT;
                end else begin
                    state_d = POP;
                end
            end
            PUSH: begin
                stack_push    = 1'b1;
                stack_type_in = 1'b1;
                stack_var_in  = var_q;
                stack_val_in  = val_q;
                assign_valid  = 1'b1;
                assign_var    = var_q;
                assign_val    = val_q;
                state_d       = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            UNSAT: begin
                unsat   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign backtrack_depth = depth_q;

endmodule

// File: tb/tb_backtrack_unit.sv
// Bench for backtrack_unit: a behavioural trail stack plus a per-cycle expected trace
// derived from the stack contents, checked every cycle on the falling edge.
module tb_backtrack_unit;
    localparam int VW = 128;
    localparam int NV = 8;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset, start, stack_empty, stack_type_out, stack_val_out;
    logic [VW-1:0] stack_var_out;
    logic          stack_pop, stack_push, stack_type_in, stack_val_in;
    logic [VW-1:0] stack_var_in, unassign_var, assign_var;
    logic          unassign_valid, assign_valid, assign_val, done, unsat, busy;
    logic [DW-1:0] backtrack_depth;

    backtrack_unit #(.VARIABLE_INDEXES(VW), .NUM_VARIABLE(NV)) dut (
        .clock(clock), .reset(reset), .start(start), .stack_empty(stack_empty),
        .stack_type_out(stack_type_out), .stack_val_out(stack_val_out),
        .stack_var_out(stack_var_out), .stack_pop(stack_pop), .stack_push(stack_push),
        .stack_type_in(stack_type_in), .stack_val_in(stack_val_in),
        .stack_var_in(stack_var_in), .unassign_valid(unassign_valid),
        .unassign_var(unassign_var), .assign_valid(assign_valid), .assign_var(assign_var),
        .assign_val(assign_val), .done(done), .unsat(unsat), .busy(busy),
        .backtrack_depth(backtrack_depth)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Behavioural trail stack: index stk_n-1 is the top.
    logic          st_type [0:31];
    logic          st_val  [0:31];
    logic [VW-1:0] st_var  [0:31];
    int            stk_n = 0;
    logic          pop_s = 1'b0, push_s = 1'b0, psh_type, psh_val;
    logic [VW-1:0] psh_var;

    assign stack_empty = (stk_n == 0);

    always @(negedge clock) begin
        pop_s    = stack_pop;
        push_s   = stack_push;
        psh_type = stack_type_in;
        psh_val  = stack_val_in;
        psh_var  = stack_var_in;
    end

    always @(posedge clock) begin
        if (reset && !pop_s) begin
            stack_type_out <= 1'b0;
            stack_val_out  <= 1'b0;
            stack_var_out  <= '0;
        end
        if (pop_s && stk_n > 0) begin
            stack_type_out <= st_type[stk_n-1];
            stack_val_out  <= st_val[stk_n-1];
            stack_var_out  <= st_var[stk_n-1];
            stk_n          <= stk_n - 1;
        end else if (push_s) begin
            st_type[stk_n] <= psh_type;
            st_val[stk_n]  <= psh_val;
            st_var[stk_n]  <= psh_var;
            stk_n          <= stk_n + 1;
        end
    end

    task automatic push_entry(input logic t, input logic v, input logic [VW-1:0] x);
        st_type[stk_n] = t;
        st_val[stk_n]  = v;
        st_var[stk_n]  = x;
        stk_n          = stk_n + 1;
    endtask

    // Expected outputs for one cycle
    typedef struct {
        logic          pop, push, type_in, val_in, uv, av, aval, dn, us, busy;
        logic [VW-1:0] var_in, uvar, avar;
        logic [DW-1:0] depth;
    } exp_t;

    exp_t exp_q[$];
    int   last_depth = 0;
    int   cyc_idx, done_cyc, unsat_cyc, done_cnt;

    function automatic exp_t idle_e(input int d);
        exp_t e;
        e.pop = 0; e.push = 0; e.type_in = 0; e.val_in = 0; e.uv = 0; e.av = 0;
        e.aval = 0; e.dn = 0; e.us = 0; e.busy = 0;
        e.var_in = '0; e.uvar = '0; e.avar = '0;
        e.depth = DW'(d);
        return e;
    endfunction

    // Walk the trail from the top: every entry costs a pop and an unassign; the first
    // decision ends the walk with a flipped forced push, running out of entries is unsat.
    task automatic build_trace();
        exp_t e;
        int   d, i;
        bit   fin;
        exp_q.push_back(idle_e(last_depth));
        if (stk_n == 0) begin
            e = idle_e(0); e.busy = 1; e.us = 1; exp_q.push_back(e);
            last_depth = 0;
            exp_q.push_back(idle_e(0));
            return;
        end
        d = 0; i = stk_n - 1; fin = 0;
        while (!fin) begin
            e = idle_e(d); e.busy = 1; e.pop = 1; exp_q.push_back(e);
            e = idle_e(d); e.busy = 1; e.uv = 1; e.uvar = st_var[i]; exp_q.push_back(e);
            if (d < NV) d++;
            if (!st_type[i]) begin
                e = idle_e(d); e.busy = 1; e.push = 1; e.type_in = 1;
                e.var_in = st_var[i]; e.val_in = ~st_val[i];
                e.av = 1; e.avar = st_var[i]; e.aval = ~st_val[i];
                exp_q.push_back(e);
                e = idle_e(d); e.busy = 1; e.dn = 1; exp_q.push_back(e);
                fin = 1;
            end else if (i == 0) begin
                e = idle_e(d); e.busy = 1; e.us = 1; exp_q.push_back(e);
                fin = 1;
            end
            i--;
        end
        last_depth = d;
        exp_q.push_back(idle_e(d));
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_idx++;
            chk("pop_push_exclusive", {127'd0, stack_pop & stack_push}, '0);
            chk("stack_pop", {127'd0, stack_pop}, {127'd0, e.pop});
            chk("stack_push", {127'd0, stack_push}, {127'd0, e.push});
            chk("stack_type_in", {127'd0, stack_type_in}, {127'd0, e.type_in});
            chk("stack_val_in", {127'd0, stack_val_in}, {127'd0, e.val_in});
            chk("stack_var_in", stack_var_in, e.var_in);
            chk("unassign_valid", {127'd0, unassign_valid}, {127'd0, e.uv});
            chk("unassign_var", unassign_var, e.uvar);
            chk("assign_valid", {127'd0, assign_valid}, {127'd0, e.av});
            chk("assign_var", assign_var, e.avar);
            chk("assign_val", {127'd0, assign_val}, {127'd0, e.aval});
            chk("done", {127'd0, done}, {127'd0, e.dn});
            chk("unsat", {127'd0, unsat}, {127'd0, e.us});
            chk("busy", {127'd0, busy}, {127'd0, e.busy});
            chk("backtrack_depth", {124'd0, backtrack_depth}, {124'd0, e.depth});
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc_idx;
            end
            if (unsat && unsat_cyc == 0) unsat_cyc = cyc_idx;
        end
    end

    task automatic wait_trace();
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge clock);
        chk("trace_completed", VW'(exp_q.size()), '0);
        exp_q.delete();
        @(posedge clock); #1;
    endtask

    // Starts a backtrack in the current cycle, holding start for hold cycles.
    task automatic run_scn(input int hold);
        cyc_idx = 0; done_cyc = 0; unsat_cyc = 0; done_cnt = 0;
        build_trace();
        start = 1'b1;
        repeat (hold) begin @(posedge clock); #1; end
        start = 1'b0;
        wait_trace();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1;
        stk_n = 0;
        push_entry(1'b0, 1'b0, VW'(5));
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(idle_e(0));
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        exp_q.push_back(idle_e(0));
        wait_trace();
        chk("reset_beats_start_no_pop", VW'(stk_n), VW'(1));

        // decision on top of a forced entry
        stk_n = 0;
        push_entry(1'b1, 1'b0, VW'(3));
        push_entry(1'b0, 1'b1, VW'(17));
        run_scn(1);
        chk("single_done_cycle", VW'(done_cyc), VW'(5));
        chk("single_depth", VW'(backtrack_depth), VW'(1));
        chk("single_stk_n", VW'(stk_n), VW'(2));
        chk("single_top_var", st_var[1], VW'(17));
        chk("single_top_type_val", VW'({st_type[1], st_val[1]}), VW'(2'b10));

        // forced(13,1) over decide(12,0)
        stk_n = 0;
        push_entry(1'b0, 1'b0, VW'(12));
        push_entry(1'b1, 1'b1, VW'(13));
        run_scn(1);
        chk("two_done_cycle", VW'(done_cyc), VW'(7));
        chk("two_depth", VW'(backtrack_depth), VW'(2));
        chk("two_stk_n", VW'(stk_n), VW'(1));
        chk("two_top_var", st_var[0], VW'(12));
        chk("two_top_type_val", VW'({st_type[0], st_val[0]}), VW'(2'b11));

        // empty trail
        stk_n = 0;
        run_scn(1);
        chk("empty_unsat_cycle", VW'(unsat_cyc), VW'(2));
        chk("empty_no_done", VW'(done_cnt), VW'(0));
        chk("empty_depth", VW'(backtrack_depth), VW'(0));

        // only a forced entry
        stk_n = 0;
        push_entry(1'b1, 1'b1, VW'(69));
        run_scn(1);
        chk("forced_unsat_cycle", VW'(unsat_cyc), VW'(4));
        chk("forced_depth", VW'(backtrack_depth), VW'(1));
        chk("forced_stk_n", VW'(stk_n), VW'(0));

        // start held through POP/CHECK/POP
        stk_n = 0;
        push_entry(1'b0, 1'b0, VW'(12));
        push_entry(1'b1, 1'b1, VW'(13));
        run_scn(4);
        chk("retrigger_done_count", VW'(done_cnt), VW'(1));
        chk("retrigger_done_cycle", VW'(done_cyc), VW'(7));

        // nine forced entries over a decision: depth saturates
        stk_n = 0;
        push_entry(1'b0, 1'b1, VW'(40));
        for (int i = 0; i < 9; i++) push_entry(1'b1, 1'b0, VW'(100 + i));
        run_scn(1);
        chk("sat_depth", VW'(backtrack_depth), VW'(8));
        chk("sat_done_cycle", VW'(done_cyc), VW'(23));

        // reset during CHECK
        stk_n = 0;
        push_entry(1'b0, 1'b0, VW'(8));
        push_entry(1'b1, 1'b1, VW'(7));
        begin
            exp_t e;
            cyc_idx = 0; done_cyc = 0; unsat_cyc = 0; done_cnt = 0;
            exp_q.push_back(idle_e(last_depth));
            e = idle_e(0); e.busy = 1; e.pop = 1; exp_q.push_back(e);
            e = idle_e(0); e.busy = 1; e.uv = 1; e.uvar = VW'(7); exp_q.push_back(e);
            exp_q.push_back(idle_e(0));
            exp_q.push_back(idle_e(0));
            last_depth = 0;
        end
        start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        wait_trace();
        chk("reset_abort_stk_n", VW'(stk_n), VW'(1));
        chk("reset_abort_no_done", VW'(done_cnt), VW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
